vde_palette_emitter: RTL and testbench

VDE_PALETTE_EMITTER -- requirements
Module: vde_palette_emitter

---
 rtl/vde_palette_emitter_if.sv | 54 +++++
 rtl/vde_palette_emitter.sv | 190 +++++++++++++++++++
 tb/tb_vde_palette_emitter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vde_palette_emitter_if.sv
// ---------------------------------------------------------------------------
// vde_palette_emitter_if
//
// Bundles the three handshake/bus groups of the palette emitter:
//   index stream   : color_valid_i, color_ready_o, color_data_i [COLOR_W]
//   pixel stream   : pixel_valid_o, pixel_ready_i, pixel_data_o [PIXEL_W]
//   palette memory : pixel_mem_addr_o [COLOR_W], pixel_mem_en_o,
//                    pixel_mem_data_i [PIXEL_W]
// Member names carry the direction as seen from the emitter.
//
// Modports:
//   slave  - the emitter (consumes indices, produces pixels, reads palette)
//   master - the environment (index source, pixel sink, palette memory)
// ---------------------------------------------------------------------------
interface vde_palette_emitter_if #(
    parameter int COLOR_W = 8,
    parameter int PIXEL_W = 24
);
    logic               color_valid_i;
    logic               color_ready_o;
    logic [COLOR_W-1:0] color_data_i;

    logic               pixel_valid_o;
    logic               pixel_ready_i;
    logic [PIXEL_W-1:0] pixel_data_o;

    logic [COLOR_W-1:0] pixel_mem_addr_o;
    logic               pixel_mem_en_o;
    logic [PIXEL_W-1:0] pixel_mem_data_i;

    modport slave (
        input  color_valid_i,
        input  color_data_i,
        input  pixel_ready_i,
        input  pixel_mem_data_i,
        output color_ready_o,
        output pixel_valid_o,
        output pixel_data_o,
        output pixel_mem_addr_o,
        output pixel_mem_en_o
    );

    modport master (
        output color_valid_i,
        output color_data_i,
        output pixel_ready_i,
        output pixel_mem_data_i,
        input  color_ready_o,
        input  pixel_valid_o,
        input  pixel_data_o,
        input  pixel_mem_addr_o,
        input  pixel_mem_en_o
    );
endinterface

// File: rtl/vde_palette_emitter.sv
// ---------------------------------------------------------------------------
// vde_palette_emitter
//
// Converts a stream of palette indices into a stream of pixels. Each accepted
// index is presented to an external palette memory with MEM_LAT cycles of read
// latency; the returned word lands in a small output FIFO. A credit counter
// covers both in-flight reads and stored entries, so a read is only issued
// when a FIFO slot is guaranteed for it and the index side never has to
// look at pixel_ready_i.
//
// Parameters:
//   COLOR_W - palette index width (also palette address width)
//   PIXEL_W - pixel / palette word width
//   MEM_LAT - palette read latency in cycles, legal 1..4
//
// Ports:
//   clk_i         - clock, rising edge
//   rstn_i        - asynchronous active-low reset
//   frame_start_i - synchronous flush of everything in flight or stored
//   direct_i      - (VDE_EMITTER_RGB332_EN only) index is an RGB332 colour
//   bus           - vde_palette_emitter_if.slave: index stream, pixel stream,
//                   palette read port
//
// Optional feature, macro VDE_EMITTER_RGB332_EN: adds direct_i. A direct
// entry skips the palette read and expands the 8-bit index as RGB332 into a
// 24-bit pixel, with the same latency and ordering as palette entries. Only
// legal with COLOR_W = 8 and PIXEL_W = 24.
// ---------------------------------------------------------------------------
module vde_palette_emitter #(
    parameter int COLOR_W = 8,
    parameter int PIXEL_W = 24,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 frame_start_i,
`ifdef VDE_EMITTER_RGB332_EN
    input  logic                 direct_i,
`endif
    vde_palette_emitter_if.slave bus
);

    localparam int DEPTH = MEM_LAT + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

`ifdef VDE_EMITTER_RGB332_EN
    // Bit replication so that full-scale channel codes map to 0xFF.
    function automatic logic [23:0] rgb332(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6],
                c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction
`endif

    // Control state
    logic [CNT_W-1:0]   cnt;        // in-flight reads + FIFO entries
    logic [CNT_W-1:0]   occ;        // FIFO entries only
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [MEM_LAT-1:0] vld_sr;     // one bit per outstanding read slot
    logic               pixel_valid;
    logic [PIXEL_W-1:0] pixel_data;

    // Storage (no reset: every entry is qualified by occ/rd_ptr)
    logic [PIXEL_W-1:0] fifo_mem [DEPTH];

    // Combinational helpers
    logic [COLOR_W-1:0] color_idx;
    logic               ready;
    logic               accept;
    logic               pop;
    logic               push;
    logic [PIXEL_W-1:0] push_data;
    logic [MEM_LAT:0]   vld_ext;
    logic [PTR_W-1:0]   rd_next;
    logic [CNT_W-1:0]   occ_left;
    logic [CNT_W-1:0]   occ_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [PIXEL_W-1:0] head_next;

    assign color_idx = bus.color_data_i;

    // Ready depends only on the credit register and the flush input.
    assign ready  = (cnt < CNT_W'(DEPTH)) && !frame_start_i;
    assign accept = bus.color_valid_i && ready;
    // A pop coinciding with a flush is ignored: the flush wins.
    assign pop    = pixel_valid && bus.pixel_ready_i && !frame_start_i;

    assign bus.color_ready_o    = ready;
    assign bus.pixel_valid_o    = pixel_valid;
    assign bus.pixel_data_o     = pixel_data;
    assign bus.pixel_mem_addr_o = color_idx;

    // Oldest slot of the shift register marks the cycle the read data returns.
    assign vld_ext = {vld_sr, accept};
    assign push    = vld_sr[MEM_LAT-1];

`ifdef VDE_EMITTER_RGB332_EN
    // Direct flag and index ride alongside the valid bits so the RGB332
    // expansion is produced in the same cycle a palette word would land.
    logic [MEM_LAT-1:0]              dir_sr;
    logic [MEM_LAT:0]                dir_ext;
    logic [MEM_LAT-1:0][COLOR_W-1:0] col_sr;
    logic [MEM_LAT:0][COLOR_W-1:0]   col_ext;

    assign dir_ext            = {dir_sr, direct_i};
    assign col_ext            = {col_sr, color_idx};
    assign bus.pixel_mem_en_o = accept && !direct_i;
    assign push_data          = dir_sr[MEM_LAT-1] ? rgb332(col_sr[MEM_LAT-1])
                                                  : bus.pixel_mem_data_i;

    always_ff @(posedge clk_i) begin
        dir_sr <= dir_ext[MEM_LAT-1:0];
        col_sr <= col_ext[MEM_LAT-1:0];
    end
`else
    assign bus.pixel_mem_en_o = accept;
    assign push_data          = bus.pixel_mem_data_i;
`endif

    // Next-state: FIFO occupancy, head register and credits
    always_comb begin
        rd_next   = pop ? ptr_inc(rd_ptr) : rd_ptr;
        occ_left  = occ - CNT_W'(pop);
        occ_next  = occ_left + CNT_W'(push);

        // The head register must already hold the next entry when it becomes
        // visible. If the FIFO would run empty after this pop, the entry
        // being written this cycle (if any) goes straight to the head.
        head_next = pixel_data;
        if (occ_left != '0) begin
            head_next = fifo_mem[rd_next];
        end else if (push) begin
            head_next = push_data;
        end

        cnt_next = cnt;
        if (accept && !pop) begin
            cnt_next = cnt + 1'b1;
        end else if (!accept && pop) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Registered control and output stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt         <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            vld_sr      <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
        end else if (frame_start_i) begin
            cnt         <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            vld_sr      <= '0;
            pixel_valid <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            occ         <= occ_next;
            vld_sr      <= vld_ext[MEM_LAT-1:0];
            rd_ptr      <= rd_next;
            if (push) begin
                wr_ptr  <= ptr_inc(wr_ptr);
            end
            pixel_valid <= (occ_next != '0);
            pixel_data  <= head_next;
        end
    end

    // FIFO storage write; credits guarantee a free slot for every push.
    always_ff @(posedge clk_i) begin
        if (push && !frame_start_i) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_vde_palette_emitter.sv
module tb_vde_palette_emitter;

    logic clk = 1'b0;
    logic rstn;
    logic fs_a;
    logic fs_b;
`ifdef VDE_EMITTER_RGB332_EN
    logic a_direct;
`endif

    always #5 clk = ~clk;

    vde_palette_emitter_if #(.COLOR_W(8), .PIXEL_W(24)) ifa ();
    vde_palette_emitter_if #(.COLOR_W(8), .PIXEL_W(24)) ifb ();

    // Instance A: MEM_LAT = 1 (DEPTH 3)
    vde_palette_emitter #(.COLOR_W(8), .PIXEL_W(24), .MEM_LAT(1)) dut_a (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .frame_start_i (fs_a),
`ifdef VDE_EMITTER_RGB332_EN
        .direct_i      (a_direct),
`endif
        .bus           (ifa)
    );

    // Instance B: MEM_LAT = 2 (DEPTH 4), used for the backpressure sequence
    vde_palette_emitter #(.COLOR_W(8), .PIXEL_W(24), .MEM_LAT(2)) dut_b (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .frame_start_i (fs_b),
`ifdef VDE_EMITTER_RGB332_EN
        .direct_i      (1'b0),
`endif
        .bus           (ifb)
    );

    // Palette memory models; unrequested reads return a marker word
    logic [23:0] pal [256];
    logic [23:0] a_rd1;
    logic [23:0] b_rd1;
    logic [23:0] b_rd2;

    always @(posedge clk) begin
        a_rd1 <= ifa.pixel_mem_en_o ? pal[ifa.pixel_mem_addr_o] : 24'hBADBAD;
        b_rd1 <= ifb.pixel_mem_en_o ? pal[ifb.pixel_mem_addr_o] : 24'hBADBAD;
        b_rd2 <= b_rd1;
    end
    assign ifa.pixel_mem_data_i = a_rd1;
    assign ifb.pixel_mem_data_i = b_rd2;

    int tests;
    int fails;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

`ifdef VDE_EMITTER_RGB332_EN
    function automatic logic [23:0] exp_rgb332(input logic [7:0] c);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = {c[7:5], c[7:5], c[7:6]};
        g = {c[4:2], c[4:2], c[4:3]};
        b = {4{c[1:0]}};
        return {r, g, b};
    endfunction
`endif

    // Scoreboard for instance A: expected pixel queued on each accept,
    // compared on each pop, dropped on flush or reset.
    logic [23:0] sbq [$];
    logic [23:0] sb_exp;

    always @(negedge clk) begin
        if (!rstn || fs_a) begin
            sbq.delete();
        end else begin
            if (ifa.pixel_valid_o && ifa.pixel_ready_i) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: pixel 0x%0h with nothing expected",
                             ifa.pixel_data_o);
                end else begin
                    sb_exp = sbq.pop_front();
                    check("sb_data", 32'(ifa.pixel_data_o), 32'(sb_exp));
                end
            end
            if (ifa.color_valid_i && ifa.color_ready_o) begin
`ifdef VDE_EMITTER_RGB332_EN
                sbq.push_back(a_direct ? exp_rgb332(ifa.color_data_i)
                                       : pal[ifa.color_data_i]);
`else
                sbq.push_back(pal[ifa.color_data_i]);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  idx;
        logic [23:0] pix;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          acc;
        int          outs;
        int          low;
        int          nv;
        int          first_v;
        int          last_v;
        int          stale;
        int          held_bad;
        logic [23:0] d0;
        logic [23:0] e;

        tests = 0;
        fails = 0;

        vecs[0] = '{8'h05, 24'h123456};
        vecs[1] = '{8'h00, 24'h000000};
        vecs[2] = '{8'hFF, 24'hFFFFFF};
        vecs[3] = '{8'h80, 24'hA5A5A5};
        vecs[4] = '{8'h7F, 24'h5A5A5A};
        vecs[5] = '{8'h3C, 24'hC0FFEE};

        for (int i = 0; i < 256; i++) begin
            pal[i] = 24'($urandom());
        end
        for (int i = 0; i < NV; i++) begin
            pal[vecs[i].idx] = vecs[i].pix;
        end

        rstn = 1'b0;
        fs_a = 1'b0;
        fs_b = 1'b0;
`ifdef VDE_EMITTER_RGB332_EN
        a_direct = 1'b0;
`endif
        ifa.color_valid_i = 1'b0;
        ifa.color_data_i  = '0;
        ifa.pixel_ready_i = 1'b1;
        ifb.color_valid_i = 1'b0;
        ifb.color_data_i  = '0;
        ifb.pixel_ready_i = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(ifa.pixel_valid_o), 32'd0);
        check("rst_data", 32'(ifa.pixel_data_o), 32'd0);
        check("rst_ready", 32'(ifa.color_ready_o), 32'd1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();

        // Single-pixel vectors: valid exactly MEM_LAT+1 = 2 cycles after accept
        for (int i = 0; i < NV; i++) begin
            ifa.color_valid_i = 1'b1;
            ifa.color_data_i  = vecs[i].idx;
            @(negedge clk);
            check("vec_accept", 32'(ifa.color_ready_o), 32'd1);
            step();
            ifa.color_valid_i = 1'b0;
            @(negedge clk);
            check("vec_early", 32'(ifa.pixel_valid_o), 32'd0);
            step();
            @(negedge clk);
            check("vec_valid", 32'(ifa.pixel_valid_o), 32'd1);
            check("vec_data", 32'(ifa.pixel_data_o), 32'(vecs[i].pix));
            step();
            @(negedge clk);
            check("vec_drain", 32'(ifa.pixel_valid_o), 32'd0);
            step();
        end

        // Streaming 0..255 back-to-back
        low = 0; nv = 0; first_v = -1; last_v = -1;
        for (int i = 0; i < 262; i++) begin
            ifa.color_valid_i = (i < 256);
            ifa.color_data_i  = 8'(i);
            @(negedge clk);
            if (i < 256 && !ifa.color_ready_o) low++;
            if (ifa.pixel_valid_o) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nv++;
            end
            step();
        end
        ifa.color_valid_i = 1'b0;
        check("stream_ready_low", 32'(low), 32'd0);
        check("stream_count", 32'(nv), 32'd256);
        check("stream_first", 32'(first_v), 32'd2);
        check("stream_last", 32'(last_v), 32'd257);

        // Backpressure on instance B (MEM_LAT = 2): 4 credits
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            ifb.color_valid_i = 1'b1;
            ifb.color_data_i  = 8'h50 + 8'(i);
            @(negedge clk);
            if (ifb.color_valid_i && ifb.color_ready_o) begin
                acc++;
                e = pal[ifb.color_data_i];
                sbq.push_back(e);  // net-zero on the instance A scoreboard
                void'(sbq.pop_back());
            end
            step();
        end
        ifb.color_valid_i = 1'b0;
        @(negedge clk);
        check("bp_accepts", 32'(acc), 32'd4);
        check("bp_ready_low", 32'(ifb.color_ready_o), 32'd0);
        check("bp_valid", 32'(ifb.pixel_valid_o), 32'd1);
        d0 = ifb.pixel_data_o;
        held_bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            if (ifb.pixel_data_o !== d0) held_bad++;
        end
        check("bp_hold", 32'(held_bad), 32'd0);
        step();
        ifb.pixel_ready_i = 1'b1;
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifb.pixel_valid_o) begin
                if (outs < 4) begin
                    check("bp_data", 32'(ifb.pixel_data_o), 32'(pal[8'h50 + 8'(outs)]));
                end
                outs++;
            end else if (outs < 4) begin
                check("bp_gap", 32'(ifb.pixel_valid_o), 32'd1);
            end
            step();
        end
        check("bp_out_count", 32'(outs), 32'd4);
        ifb.pixel_ready_i = 1'b0;

        // Flush with 3 entries in flight/stored
        ifa.pixel_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifa.color_valid_i = 1'b1;
            ifa.color_data_i  = 8'h20 + 8'(k);
            @(negedge clk);
            check("flush_fill", 32'(ifa.color_ready_o), 32'd1);
            step();
        end
        fs_a = 1'b1;
        ifa.color_data_i = 8'h30;
        @(negedge clk);
        check("flush_ready_low", 32'(ifa.color_ready_o), 32'd0);
        step();
        fs_a = 1'b0;
        ifa.color_data_i  = 8'h31;
        ifa.pixel_ready_i = 1'b1;
        @(negedge clk);
        check("flush_valid_cleared", 32'(ifa.pixel_valid_o), 32'd0);
        check("flush_ready_back", 32'(ifa.color_ready_o), 32'd1);
        step();
        ifa.color_valid_i = 1'b0;
        @(negedge clk);
        check("flush_early", 32'(ifa.pixel_valid_o), 32'd0);
        step();
        @(negedge clk);
        check("flush_new_valid", 32'(ifa.pixel_valid_o), 32'd1);
        check("flush_new_data", 32'(ifa.pixel_data_o), 32'(pal[8'h31]));
        step();
        @(negedge clk);
        check("flush_no_stale", 32'(ifa.pixel_valid_o), 32'd0);
        step();

`ifdef VDE_EMITTER_RGB332_EN
        a_direct = 1'b1;
        ifa.color_valid_i = 1'b1;
        ifa.color_data_i  = 8'hE3;
        @(negedge clk);
        check("rgb_mem_en", 32'(ifa.pixel_mem_en_o), 32'd0);
        step();
        a_direct = 1'b0;
        ifa.color_valid_i = 1'b0;
        step();
        @(negedge clk);
        check("rgb_valid", 32'(ifa.pixel_valid_o), 32'd1);
        check("rgb_data", 32'(ifa.pixel_data_o), 32'h00FF00FF);
        step();
`endif

        check("sb_drained", 32'(sbq.size()), 32'd0);

        // Asynchronous reset with the credit counter full
        ifa.pixel_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifa.color_valid_i = 1'b1;
            ifa.color_data_i  = 8'h40 + 8'(k);
            @(negedge clk);
            check("rst_fill", 32'(ifa.color_ready_o), 32'd1);
            step();
        end
        ifa.color_valid_i = 1'b0;
        step();
        @(negedge clk);
        check("rst_full_ready", 32'(ifa.color_ready_o), 32'd0);
        check("rst_full_valid", 32'(ifa.pixel_valid_o), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_valid", 32'(ifa.pixel_valid_o), 32'd0);
        check("rst_async_data", 32'(ifa.pixel_data_o), 32'd0);
        check("rst_async_ready", 32'(ifa.color_ready_o), 32'd1);
        @(negedge clk);
        #2 rstn = 1'b1;
        ifa.pixel_ready_i = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.pixel_valid_o) stale++;
        end
        check("rst_no_stale", 32'(stale), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
